ann_coef_loader: RTL and testbench

ANN_COEF_LOADER -- requirements
Module: ann_coef_loader

---
 rtl/ann_pkg.sv | 49 ++++
 rtl/ann_coef_addr_gen.sv | 40 ++++
 rtl/ann_coef_loader.sv | 165 ++++++++++++++++
 tb/tb_ann_coef_loader.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ann_pkg.sv
// Shared definitions for the ANN coefficient loader and controller: FSM states, layer sizes, word counts.
// Optional feature macro: ANN_COEF_BIAS_EN (adds one bias word per output node to every layer).
package ann_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DATA = 2'd2,
        DONE      = 2'd3
    } ann_coef_state_e;

    localparam int ANN_IMAGE_SIZE   = 64;
    localparam int ANN_FIRST_LAYER  = 16;
    localparam int ANN_SECOND_LAYER = 4;
    localparam int ANN_THIRD_LAYER  = 10;
    localparam int ANN_LAYER_CNT    = 3;

    // Buffer index width; the largest layer (1040 words with biases) fits in 11 bits.
    localparam int IDX_W = 11;

    function automatic int coef_words(input logic [1:0] layer,
                                      input int image_size,
                                      input int first_layer,
                                      input int second_layer,
                                      input int third_layer);
        int n_in;
        int n_out;
        case (layer)
            2'd0: begin
                n_in  = image_size;
                n_out = first_layer;
            end
            2'd1: begin
                n_in  = first_layer;
                n_out = second_layer;
            end
            default: begin
                n_in  = second_layer;
                n_out = third_layer;
            end
        endcase
`ifdef ANN_COEF_BIAS_EN
        return n_in * n_out + n_out;
`else
        return n_in * n_out;
`endif
    endfunction

endpackage

// File: rtl/ann_coef_addr_gen.sv
// Word-index counter and base-plus-index read address for the coefficient loader.
module ann_coef_addr_gen
    import ann_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  inc,
    input  logic [ADDR_WIDTH-1:0] base,
    output logic [IDX_W-1:0]      index,
    output logic [ADDR_WIDTH-1:0] addr
);

    logic [IDX_W-1:0] index_q;
    logic [IDX_W-1:0] index_d;

    always_comb begin
        index_d = index_q;
        if (clr) begin
            index_d = '0;
        end else if (inc) begin
            index_d = index_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            index_q <= '0;
        end else begin
            index_q <= index_d;
        end
    end

    assign index = index_q;
    // Address wraps modulo 2**ADDR_WIDTH.
    assign addr  = base + ADDR_WIDTH'(index_q);

endmodule

// File: rtl/ann_coef_loader.sv
// Fetches one layer of ANN coefficients from memory into the coefficient buffer, one read at a time.
// Optional feature macro: ANN_COEF_BIAS_EN (bias words fetched after the weights of each layer).
module ann_coef_loader
    import ann_pkg::*;
#(
    parameter int IMAGE_SIZE   = ANN_IMAGE_SIZE,
    parameter int FIRST_LAYER  = ANN_FIRST_LAYER,
    parameter int SECOND_LAYER = ANN_SECOND_LAYER,
    parameter int THIRD_LAYER  = ANN_THIRD_LAYER,
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 16,
    parameter int L0_BASE      = 0,
    parameter int L1_BASE      = 2048,
    parameter int L2_BASE      = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  request_coef,
    input  logic                  done_processing,
    output logic                  mem_read,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rvalid,
    output logic                  buf_wen,
    output logic [10:0]           buf_waddr,
    output logic [DATA_WIDTH-1:0] buf_wdata,
    output logic                  coef_loaded,
    output logic [1:0]            layer_idx,
    output logic                  busy,
    output logic                  overrun
);

    ann_coef_state_e state_q;
    ann_coef_state_e state_d;
    logic [1:0]      layer_q;
    logic [1:0]      layer_d;
    logic            overrun_q;
    logic            overrun_d;
    logic            dp_pend_q;
    logic            dp_pend_d;

    logic                  idx_clr;
    logic                  idx_inc;
    logic [IDX_W-1:0]      index;
    logic [IDX_W-1:0]      last_idx;
    logic [ADDR_WIDTH-1:0] layer_base;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  mem_read_c;
    logic                  wen_c;
    logic                  loaded_c;

    ann_coef_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk   (clk),
        .rst   (rst),
        .clr   (idx_clr),
        .inc   (idx_inc),
        .base  (layer_base),
        .index (index),
        .addr  (rd_addr)
    );

    always_comb begin
        case (layer_q)
            2'd0:    layer_base = ADDR_WIDTH'(L0_BASE);
            2'd1:    layer_base = ADDR_WIDTH'(L1_BASE);
            default: layer_base = ADDR_WIDTH'(L2_BASE);
        endcase
        last_idx = IDX_W'(coef_words(layer_q, IMAGE_SIZE, FIRST_LAYER,
                                     SECOND_LAYER, THIRD_LAYER) - 1);
    end

    always_comb begin
        state_d    = state_q;
        layer_d    = layer_q;
        overrun_d  = overrun_q;
        dp_pend_d  = dp_pend_q;
        idx_clr    = 1'b0;
        idx_inc    = 1'b0;
        mem_read_c = 1'b0;
        wen_c      = 1'b0;
        loaded_c   = 1'b0;

        case (state_q)
            IDLE: begin
                dp_pend_d = 1'b0;
                if (done_processing) begin
                    layer_d = 2'd0;
                end
                if (request_coef) begin
                    idx_clr = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mem_read_c = 1'b1;
                state_d    = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (mem_rvalid) begin
                    wen_c = 1'b1;
                    if (index == last_idx) begin
                        state_d = DONE;
                    end else begin
                        idx_inc = 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            DONE: begin
                loaded_c  = 1'b1;
                state_d   = IDLE;
                dp_pend_d = 1'b0;
                // An end-of-image seen during the load, or right now, wins over the advance.
                if (dp_pend_q || done_processing) begin
                    layer_d = 2'd0;
                end else if (layer_q == 2'(ANN_LAYER_CNT - 1)) begin
                    layer_d = 2'd0;
                end else begin
                    layer_d = layer_q + 2'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if ((state_q != IDLE) && request_coef) begin
            overrun_d = 1'b1;
        end
        if ((state_q != WAIT_DATA) && mem_rvalid) begin
            overrun_d = 1'b1;
        end
        if ((state_q == ISSUE || state_q == WAIT_DATA) && done_processing) begin
            dp_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            layer_q   <= 2'd0;
            overrun_q <= 1'b0;
            dp_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            layer_q   <= layer_d;
            overrun_q <= overrun_d;
            dp_pend_q <= dp_pend_d;
        end
    end

    // Strobes are masked during the reset cycle so an in-flight read cannot reach the buffer.
    assign mem_read    = mem_read_c & ~rst;
    assign mem_addr    = mem_read ? rd_addr : '0;
    assign buf_wen     = wen_c & ~rst;
    assign buf_waddr   = buf_wen ? index : '0;
    assign buf_wdata   = buf_wen ? mem_rdata : '0;
    assign coef_loaded = loaded_c & ~rst;
    assign busy        = (state_q != IDLE) & ~rst;
    assign layer_idx   = layer_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_ann_coef_loader.sv
// Directed bench for ann_coef_loader with a latency-programmable memory model and write scoreboard.
module tb_ann_coef_loader;

`ifdef ANN_COEF_BIAS_EN
    localparam int N0 = 1040;
    localparam int N1 = 68;
    localparam int N2 = 50;
`else
    localparam int N0 = 1024;
    localparam int N1 = 64;
    localparam int N2 = 40;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        request_coef;
    logic        done_processing;
    logic        mem_read;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_rvalid;
    logic        buf_wen;
    logic [10:0] buf_waddr;
    logic [15:0] buf_wdata;
    logic        coef_loaded;
    logic [1:0]  layer_idx;
    logic        busy;
    logic        overrun;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int lat   = 1;

    bit          dl_v [8];
    logic [15:0] dl_a [8];
    bit          prev_rd;
    logic [15:0] prev_addr;

    int          cur_base;
    int          rd_cnt, rd_bad, wr_cnt, wr_bad, ld_cnt, ld_len, req_cyc;
    logic [15:0] last_rd_addr;

    ann_coef_loader dut (
        .clk             (clk),
        .rst             (rst),
        .request_coef    (request_coef),
        .done_processing (done_processing),
        .mem_read        (mem_read),
        .mem_addr        (mem_addr),
        .mem_rdata       (mem_rdata),
        .mem_rvalid      (mem_rvalid),
        .buf_wen         (buf_wen),
        .buf_waddr       (buf_waddr),
        .buf_wdata       (buf_wdata),
        .coef_loaded     (coef_loaded),
        .layer_idx       (layer_idx),
        .busy            (busy),
        .overrun         (overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mdata(input logic [15:0] a);
        return (a * 16'd7) ^ 16'h5A3C;
    endfunction

    // One clock: advance the memory delay line, then record reads, writes and completions.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 7; i > 0; i--) begin
            dl_v[i] = dl_v[i-1];
            dl_a[i] = dl_a[i-1];
        end
        dl_v[0]   = prev_rd;
        dl_a[0]   = prev_addr;
        prev_rd   = mem_read;
        prev_addr = mem_addr;
        mem_rvalid = dl_v[lat-1];
        mem_rdata  = dl_v[lat-1] ? mdata(dl_a[lat-1]) : 16'hDEAD;
        #1;
        if (mem_read) begin
            if (int'(mem_addr) != cur_base + rd_cnt) rd_bad++;
            last_rd_addr = mem_addr;
            rd_cnt++;
        end
        if (buf_wen) begin
            if (int'(buf_waddr) != wr_cnt || buf_wdata !== mdata(16'(cur_base + wr_cnt))) wr_bad++;
            wr_cnt++;
        end
        if (coef_loaded) begin
            ld_cnt++;
            ld_len = cyc - req_cyc + 1;
        end
    endtask

    task automatic start_load(input int base);
        cur_base = base;
        rd_cnt = 0; rd_bad = 0; wr_cnt = 0; wr_bad = 0; ld_cnt = 0; ld_len = 0;
        request_coef = 1'b1;
        req_cyc = cyc;
        step();
        request_coef = 1'b0;
    endtask

    // Steps until coef_loaded, then 8 idle cycles to drain the memory model.
    task automatic wait_loaded(input int budget, output bit timed_out);
        int n = 0;
        timed_out = 1'b0;
        while (ld_cnt == 0 && n < budget) begin
            step();
            n++;
        end
        if (ld_cnt == 0) timed_out = 1'b1;
        for (int i = 0; i < 8; i++) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b want 0", busy); end
        tests++; if (layer_idx !== 2'd0) begin fails++; $display("FAIL reset_layer: got %0d want 0", layer_idx); end
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %0b want 0", overrun); end
        tests++; if ({mem_read, buf_wen, coef_loaded} !== 3'b000)
            begin fails++; $display("FAIL reset_strobes: got %b want 000", {mem_read, buf_wen, coef_loaded}); end
        tests++; if ({mem_addr, buf_waddr, buf_wdata} !== 43'd0)
            begin fails++; $display("FAIL reset_buses: got %h want 0", {mem_addr, buf_waddr, buf_wdata}); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_layer0_lat1();
        bit to;
        lat = 1;
        start_load(0);
        wait_loaded(5000, to);
        tests++; if (to) begin fails++; $display("FAIL l0_timeout: got no coef_loaded want one"); end
        tests++; if (rd_cnt != N0 || rd_bad != 0) begin fails++; $display("FAIL l0_reads: got %0d (bad %0d) want %0d", rd_cnt, rd_bad, N0); end
        tests++; if (wr_cnt != N0 || wr_bad != 0) begin fails++; $display("FAIL l0_writes: got %0d (bad %0d) want %0d", wr_cnt, wr_bad, N0); end
        tests++; if (ld_len != 2 * N0 + 2) begin fails++; $display("FAIL l0_latency: got %0d want %0d", ld_len, 2 * N0 + 2); end
        tests++; if (ld_cnt != 1) begin fails++; $display("FAIL l0_loaded_cnt: got %0d want 1", ld_cnt); end
        tests++; if (layer_idx !== 2'd1) begin fails++; $display("FAIL l0_layer: got %0d want 1", layer_idx); end
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL l0_overrun: got %0b want 0", overrun); end
    endtask

    task automatic test_overrun_l1();
        bit to;
        int n = 0;
        lat = 1;
        start_load(2048);
        while (wr_cnt < 10 && n < 100) begin step(); n++; end
        request_coef = 1'b1;
        step();
        request_coef = 1'b0;
        tests++; if (overrun !== 1'b1 || busy !== 1'b1)
            begin fails++; $display("FAIL ovr_flag: got overrun=%0b busy=%0b want 1 1", overrun, busy); end
        wait_loaded(1000, to);
        tests++; if (to) begin fails++; $display("FAIL ovr_timeout: got no coef_loaded want one"); end
        tests++; if (wr_cnt != N1 || wr_bad != 0) begin fails++; $display("FAIL ovr_writes: got %0d (bad %0d) want %0d", wr_cnt, wr_bad, N1); end
        tests++; if (last_rd_addr !== 16'(2048 + N1 - 1)) begin fails++; $display("FAIL l1_last_addr: got %0d want %0d", last_rd_addr, 2048 + N1 - 1); end
        tests++; if (ld_cnt != 1) begin fails++; $display("FAIL ovr_loaded_cnt: got %0d want 1", ld_cnt); end
        tests++; if (layer_idx !== 2'd2) begin fails++; $display("FAIL ovr_layer: got %0d want 2", layer_idx); end
        tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_sticky: got %0b want 1", overrun); end
    endtask

    task automatic test_layer2_lat3();
        bit to;
        lat = 3;
        start_load(4096);
        wait_loaded(1000, to);
        tests++; if (to) begin fails++; $display("FAIL l2_timeout: got no coef_loaded want one"); end
        tests++; if (wr_cnt != N2 || wr_bad != 0) begin fails++; $display("FAIL l2_writes: got %0d (bad %0d) want %0d", wr_cnt, wr_bad, N2); end
        tests++; if (ld_len != 4 * N2 + 2) begin fails++; $display("FAIL l2_latency: got %0d want %0d", ld_len, 4 * N2 + 2); end
        tests++; if (ld_cnt != 1) begin fails++; $display("FAIL l2_loaded_cnt: got %0d want 1", ld_cnt); end
        tests++; if (layer_idx !== 2'd0) begin fails++; $display("FAIL l2_layer_wrap: got %0d want 0", layer_idx); end
    endtask

    task automatic test_reset_midload();
        int n = 0;
        lat = 2;
        start_load(0);
        while (!(mem_read && mem_addr == 16'd5) && n < 100) begin step(); n++; end
        step();
        rst = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata = 16'hBEEF;
        #1;
        tests++; if (buf_wen !== 1'b0) begin fails++; $display("FAIL rstmid_wen_in_reset: got %0b want 0", buf_wen); end
        step();
        rst = 1'b0;
        #1;
        tests++; if (mem_rvalid !== 1'b1 || buf_wen !== 1'b0)
            begin fails++; $display("FAIL rstmid_late_rvalid: got rvalid=%0b wen=%0b want 1 0", mem_rvalid, buf_wen); end
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL rstmid_ovr_cleared: got %0b want 0", overrun); end
        for (int i = 0; i < 10; i++) step();
        tests++; if (wr_cnt != 5 || ld_cnt != 0)
            begin fails++; $display("FAIL rstmid_abandon: got writes=%0d loaded=%0d want 5 0", wr_cnt, ld_cnt); end
        tests++; if (busy !== 1'b0 || layer_idx !== 2'd0)
            begin fails++; $display("FAIL rstmid_idle: got busy=%0b layer=%0d want 0 0", busy, layer_idx); end
        tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL rstmid_ovr_set: got %0b want 1", overrun); end
    endtask

    task automatic test_done_idle();
        bit to;
        lat = 1;
        start_load(0);
        wait_loaded(5000, to);
        tests++; if (to || layer_idx !== 2'd1) begin fails++; $display("FAIL dpidle_setup: got layer=%0d want 1", layer_idx); end
        done_processing = 1'b1;
        step();
        done_processing = 1'b0;
        step();
        tests++; if (layer_idx !== 2'd0) begin fails++; $display("FAIL dpidle_layer: got %0d want 0", layer_idx); end
    endtask

    task automatic test_done_collide();
        bit to;
        int n = 0;
        lat = 1;
        start_load(0);
        wait_loaded(5000, to);
        start_load(2048);
        while (wr_cnt < N1 && n < 1000) begin step(); n++; end
        step();
        tests++; if (coef_loaded !== 1'b1) begin fails++; $display("FAIL dpdone_pulse: got %0b want 1", coef_loaded); end
        done_processing = 1'b1;
        step();
        done_processing = 1'b0;
        tests++; if (layer_idx !== 2'd0) begin fails++; $display("FAIL dpdone_layer: got %0d want 0", layer_idx); end
        for (int i = 0; i < 8; i++) step();
        tests++; if (ld_cnt != 1) begin fails++; $display("FAIL dpdone_loaded_cnt: got %0d want 1", ld_cnt); end
    endtask

    task automatic test_done_busy();
        bit to;
        int n = 0;
        lat = 1;
        start_load(0);
        while (wr_cnt < 100 && n < 1000) begin step(); n++; end
        done_processing = 1'b1;
        step();
        done_processing = 1'b0;
        wait_loaded(5000, to);
        tests++; if (to || wr_cnt != N0 || wr_bad != 0)
            begin fails++; $display("FAIL dpbusy_writes: got %0d (bad %0d) want %0d", wr_cnt, wr_bad, N0); end
        tests++; if (layer_idx !== 2'd0) begin fails++; $display("FAIL dpbusy_layer: got %0d want 0", layer_idx); end
    endtask

    initial begin
        rst = 1'b1;
        request_coef = 1'b0;
        done_processing = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = 16'h0;
        prev_rd = 1'b0;
        prev_addr = 16'h0;
        for (int i = 0; i < 8; i++) begin
            dl_v[i] = 1'b0;
            dl_a[i] = 16'h0;
        end
        cur_base = 0; rd_cnt = 0; rd_bad = 0; wr_cnt = 0; wr_bad = 0; ld_cnt = 0; ld_len = 0; req_cyc = 0;
        last_rd_addr = 16'h0;

        test_reset();
        test_layer0_lat1();
        test_overrun_l1();
        test_layer2_lat3();
        test_reset_midload();
        test_done_idle();
        test_done_collide();
        test_done_busy();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of run want finish before 2 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
